// File: rtl/adder_rr_scheduler.sv
// Round-robin front end sharing one N-bit adder among REQ requesters, with a single registered result stage.
// Build option: define ADDER_SAT_EN for unsigned saturation of the sum on carry-out.
module adder_rr_scheduler #(
   parameter  int N   = 32,
   parameter  int REQ = 4,
   localparam int IDW = ($clog2(REQ) > 1) ? $clog2(REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REQ-1:0]       req_valid,
   output logic [REQ-1:0]       req_ready,
   input  logic [REQ*N-1:0]     req_a,
   input  logic [REQ*N-1:0]     req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [N-1:0]         rsp_sum,
   output logic                 rsp_carry,
   output logic [IDW-1:0]       rsp_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t         state_q;
   logic [IDW-1:0] rr_ptr_q;
   logic           rsp_valid_q;
   logic [N-1:0]   rsp_sum_q;
   logic           rsp_carry_q;
   logic [IDW-1:0] rsp_id_q;

   logic [N-1:0]   a_arr [REQ];
   logic [N-1:0]   b_arr [REQ];

   generate
      for (genvar gi = 0; gi < REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*N +: N];
         assign b_arr[gi] = req_b[gi*N +: N];
      end
   endgenerate

   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic           can_accept;
   logic           accept;
   logic [N:0]     sum_full;
   logic [N-1:0]   sum_d;
   logic [IDW-1:0] rr_ptr_d;

   // First valid requester scanning upward from the pointer, wrapping modulo REQ.
   always_comb begin
      int j;
      grant_found = 1'b0;
      grant_idx   = '0;
      j           = 0;
      for (int k = 0; k < REQ; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= REQ) j = j - REQ;
         if (!grant_found && req_valid[IDW'(j)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(j);
         end
      end
   end

   assign can_accept = (state_q == EMPTY) || rsp_ready;
   assign accept     = grant_found && can_accept;

   // Ready is also forced low while reset is held, so nothing looks accepted.
   always_comb begin
      req_ready = '0;
      if (accept && rst_n) req_ready[grant_idx] = 1'b1;
   end

   assign sum_full = {1'b0, a_arr[grant_idx]} + {1'b0, b_arr[grant_idx]};

`ifdef ADDER_SAT_EN
   assign sum_d = sum_full[N] ? {N{1'b1}} : sum_full[N-1:0];
`else
   assign sum_d = sum_full[N-1:0];
`endif

   assign rr_ptr_d = (grant_idx == IDW'(REQ-1)) ? '0 : grant_idx + IDW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_carry_q <= 1'b0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= FULL;
                  rsp_valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (rsp_ready && !accept) begin
                  state_q     <= EMPTY;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= EMPTY;
               rsp_valid_q <= 1'b0;
            end
         endcase
         if (accept) begin
            rsp_sum_q   <= sum_d;
            rsp_carry_q <= sum_full[N];
            rsp_id_q    <= grant_idx;
            rr_ptr_q    <= rr_ptr_d;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed table, reset corner cases, then random traffic against a queue-free reference model.
module tb_adder_rr_scheduler;

   localparam int N   = 32;
   localparam int REQ = 4;
   localparam int IDW = 2;

   logic             clk;
   logic             rst_n;
   logic [REQ-1:0]   req_valid;
   logic [REQ-1:0]   req_ready;
   logic [REQ*N-1:0] req_a;
   logic [REQ*N-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [N-1:0]     rsp_sum;
   logic             rsp_carry;
   logic [IDW-1:0]   rsp_id;

   adder_rr_scheduler #(.N(N), .REQ(REQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state: pointer, occupancy and the held result.
   int          m_ptr;
   bit          m_full;
   logic [31:0] m_sum;
   bit          m_carry;
   int          m_id;
   logic [3:0]  obs_ready;

   typedef struct {
      logic [3:0]   v;
      logic         r;
      logic [127:0] a;
      logic [127:0] b;
      logic [3:0]   ready;
      logic         valid;
      logic [31:0]  sum;
      logic         carry;
      int           id;
   } vec_t;

   vec_t vec [24];

   function automatic logic [127:0] lanes(input logic [31:0] x3, input logic [31:0] x2,
                                          input logic [31:0] x1, input logic [31:0] x0);
      return {x3, x2, x1, x0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_full = 0; m_sum = '0; m_carry = 0; m_id = 0;
   endtask

   // One clock of traffic: drive, check combinational ready, clock, check registered result.
   task automatic cycle(input logic [3:0] v, input logic r, input logic [127:0] a, input logic [127:0] b);
      int g;
      bit found;
      logic [3:0] er;
      longint unsigned s;
      logic [31:0] av, bv;
      req_valid = v; rsp_ready = r; req_a = a; req_b = b;
      #3;
      found = 0; g = 0;
      for (int k = 0; k < REQ; k++) begin
         int i;
         i = (m_ptr + k) % REQ;
         if (!found && v[i]) begin found = 1; g = i; end
      end
      er = '0;
      if (found && (!m_full || r)) er[g] = 1'b1;
      obs_ready = req_ready;
      chk("req_ready", 64'(req_ready), 64'(er));
      @(posedge clk); #1;
      cyc++;
      if (er != 0) begin
         av = a[g*32 +: 32];
         bv = b[g*32 +: 32];
         s = 64'(av) + 64'(bv);
         m_carry = s[32];
         m_sum = s[31:0];
`ifdef ADDER_SAT_EN
         if (m_carry) m_sum = 32'hFFFF_FFFF;
`endif
         m_id = g;
         m_ptr = (g + 1) % REQ;
         m_full = 1;
      end else if (r) begin
         m_full = 0;
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      chk("rsp_sum",   64'(rsp_sum),   64'(m_sum));
      chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
      chk("rsp_id",    64'(rsp_id),    64'(m_id));
      $display("cyc %0d valid=%b rdy=%b ready=%b -> rsp_valid=%b id=%0d sum=%h carry=%b",
               cyc, v, r, obs_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry);
   endtask

   initial begin
      logic [127:0] ra, rb, ta, tb;
      logic [31:0]  ovf;
`ifdef ADDER_SAT_EN
      ovf = 32'hFFFF_FFFF;
`else
      ovf = 32'h0000_0001;
`endif
      ra = lanes(40, 30, 20, 10);
      rb = lanes(4, 3, 2, 1);
      vec[0] = '{4'b0001, 1'b1, lanes(0, 0, 0, 5), lanes(0, 0, 0, 7), 4'b0001, 1'b1, 32'd12, 1'b0, 0};
      for (int i = 0; i < 8; i++) begin
         int g;
         g = (i + 1) % REQ;
         vec[1+i] = '{4'b1111, 1'b1, ra, rb, 4'b0001 << g, 1'b1, 32'(11 * (g + 1)), 1'b0, g};
      end
      vec[9] = '{4'b0100, 1'b1, lanes(0, 3, 0, 0), lanes(0, 4, 0, 0), 4'b0100, 1'b1, 32'd7, 1'b0, 2};
      for (int i = 10; i < 15; i++)
         vec[i] = '{4'b0010, 1'b0, lanes(0, 0, 100, 0), lanes(0, 0, 1, 0), 4'b0000, 1'b1, 32'd7, 1'b0, 2};
      vec[15] = '{4'b0010, 1'b1, lanes(0, 0, 100, 0), lanes(0, 0, 1, 0), 4'b0010, 1'b1, 32'd101, 1'b0, 1};
      vec[16] = '{4'b0000, 1'b1, '0, '0, 4'b0000, 1'b0, 32'd101, 1'b0, 1};
      vec[17] = '{4'b0001, 1'b1, lanes(0, 0, 0, 32'hFFFF_FFFF), lanes(0, 0, 0, 2), 4'b0001, 1'b1, ovf, 1'b1, 0};
      vec[18] = '{4'b0100, 1'b1, lanes(0, 1, 0, 0), lanes(0, 1, 0, 0), 4'b0100, 1'b1, 32'd2, 1'b0, 2};
      vec[19] = '{4'b0110, 1'b1, lanes(0, 20, 10, 0), lanes(0, 20, 10, 0), 4'b0010, 1'b1, 32'd20, 1'b0, 1};
      vec[20] = '{4'b0110, 1'b1, lanes(0, 20, 10, 0), lanes(0, 20, 10, 0), 4'b0100, 1'b1, 32'd40, 1'b0, 2};
      vec[21] = '{4'b1000, 1'b0, lanes(7, 0, 0, 0), lanes(8, 0, 0, 0), 4'b0000, 1'b1, 32'd40, 1'b0, 2};
      vec[22] = '{4'b1000, 1'b1, lanes(7, 0, 0, 0), lanes(8, 0, 0, 0), 4'b1000, 1'b1, 32'd15, 1'b0, 3};
      vec[23] = '{4'b0000, 1'b0, '0, '0, 4'b0000, 1'b1, 32'd15, 1'b0, 3};

      // Reset held with random inputs.
      rst_n = 1'b0;
      req_valid = 4'($urandom); rsp_ready = 1'($urandom);
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      model_reset();
      repeat (3) @(posedge clk);
      #4;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
      chk("reset_rsp_carry", 64'(rsp_carry), 64'd0);
      chk("reset_rsp_id",    64'(rsp_id),    64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 24; i++) begin
         cycle(vec[i].v, vec[i].r, vec[i].a, vec[i].b);
         chk("tbl_ready", 64'(obs_ready), 64'(vec[i].ready));
         chk("tbl_valid", 64'(rsp_valid), 64'(vec[i].valid));
         chk("tbl_sum",   64'(rsp_sum),   64'(vec[i].sum));
         chk("tbl_carry", 64'(rsp_carry), 64'(vec[i].carry));
         chk("tbl_id",    64'(rsp_id),    64'(vec[i].id));
      end

      // Asynchronous reset between edges while a result is held.
      req_valid = 4'b0000; rsp_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_rsp_sum",   64'(rsp_sum),   64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(4'b1111, 1'b1, ra, rb);
      chk("post_reset_id",  64'(rsp_id),  64'd0);
      chk("post_reset_sum", 64'(rsp_sum), 64'd11);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] v;
         logic r;
         v = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < REQ; l++) begin
            ta[l*32 +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            tb[l*32 +: 32] = $urandom;
         end
         cycle(v, r, ta, tb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
